// File: rtl/hazard_ctrl_if.sv
// Decode-side inputs and forwarding/stall outputs of the hazard controller.
interface hazard_ctrl_if #(
  parameter int SEL_W = 3,
  parameter int CNT_W = 16
);
  logic [4:0]       rs_d;
  logic [4:0]       rt_d;
  logic [1:0]       tuse_rs_d;
  logic [1:0]       tuse_rt_d;
  logic [4:0]       a3_d;
  logic [1:0]       kind_d;
  logic [SEL_W-1:0] fwd_rs_d;
  logic [SEL_W-1:0] fwd_rt_d;
  logic [SEL_W-1:0] fwd_rs_e;
  logic [SEL_W-1:0] fwd_rt_e;
  logic [SEL_W-1:0] fwd_rt_m;
  logic             stall;
  logic             flush_e;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output rs_d, rt_d, tuse_rs_d, tuse_rt_d, a3_d, kind_d,
    input  fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m, stall, flush_e, stall_cnt
  );

  modport slave (
    input  rs_d, rt_d, tuse_rs_d, tuse_rt_d, a3_d, kind_d,
    output fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m, stall, flush_e, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Tracks in-flight register writes through E/M/W and derives forward selects,
// the stall/flush pair and a saturating stall counter.
module hazard_ctrl #(
  parameter int SEL_W = 3,
  parameter int CNT_W = 16
) (
  input logic          clk,
  input logic          reset,
  hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    KIND_NONE = 2'd0,
    KIND_ALU  = 2'd1,
    KIND_DM   = 2'd2,
    KIND_PC   = 2'd3
  } kind_t;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] a3;
    kind_t      kind;
    logic [1:0] tnew;
  } rec_t;

  localparam logic [SEL_W-1:0] SEL_RD   = SEL_W'(0);
  localparam logic [SEL_W-1:0] SEL_PC4E = SEL_W'(1);
  localparam logic [SEL_W-1:0] SEL_AO   = SEL_W'(2);
  localparam logic [SEL_W-1:0] SEL_PC4M = SEL_W'(3);
  localparam logic [SEL_W-1:0] SEL_WD   = SEL_W'(4);

  rec_t             rec_e, rec_m, rec_w;
  rec_t             rec_d, rec_m_next;
  logic             stall_w;
  logic [CNT_W-1:0] cnt_q;
  logic             unused_rec_bits;

  function automatic logic hit(input rec_t r, input logic [4:0] n);
    return (n != 5'd0) && (r.a3 == n) && (r.kind != KIND_NONE);
  endfunction

  // A dm result sitting in M is not yet available, so it yields "no forward".
  function automatic logic [SEL_W-1:0] sel_mw(input rec_t m, input rec_t w, input logic [4:0] n);
    logic [SEL_W-1:0] s;
    s = SEL_RD;
    if (hit(m, n)) begin
      case (m.kind)
        KIND_ALU: s = SEL_AO;
        KIND_PC:  s = SEL_PC4M;
        default:  s = SEL_RD;
      endcase
    end else if (hit(w, n)) begin
      s = SEL_WD;
    end
    return s;
  endfunction

  function automatic logic [SEL_W-1:0] sel_d(input rec_t e, input rec_t m, input rec_t w,
                                             input logic [4:0] n);
    if (hit(e, n)) return (e.kind == KIND_PC) ? SEL_PC4E : SEL_RD;
    return sel_mw(m, w, n);
  endfunction

  function automatic logic need_stall(input rec_t e, input rec_t m, input logic [4:0] n,
                                      input logic [1:0] tuse);
    return (tuse != 2'd3) &&
           ((hit(e, n) && (e.tnew > tuse)) || (hit(m, n) && (m.tnew > tuse)));
  endfunction

  always_comb begin
    rec_d      = '0;
    rec_d.rs   = hz.rs_d;
    rec_d.rt   = hz.rt_d;
    rec_d.a3   = hz.a3_d;
    rec_d.kind = kind_t'(hz.kind_d);
    case (rec_d.kind)
      KIND_ALU: rec_d.tnew = 2'd1;
      KIND_DM:  rec_d.tnew = 2'd2;
      default:  rec_d.tnew = 2'd0;
    endcase

    rec_m_next      = rec_e;
    rec_m_next.tnew = (rec_e.tnew != 2'd0) ? rec_e.tnew - 2'd1 : 2'd0;

    stall_w = need_stall(rec_e, rec_m, hz.rs_d, hz.tuse_rs_d) |
              need_stall(rec_e, rec_m, hz.rt_d, hz.tuse_rt_d);

    hz.fwd_rs_d  = sel_d(rec_e, rec_m, rec_w, hz.rs_d);
    hz.fwd_rt_d  = sel_d(rec_e, rec_m, rec_w, hz.rt_d);
    hz.fwd_rs_e  = sel_mw(rec_m, rec_w, rec_e.rs);
    hz.fwd_rt_e  = sel_mw(rec_m, rec_w, rec_e.rt);
    hz.fwd_rt_m  = hit(rec_w, rec_m.rt) ? SEL_WD : SEL_RD;
    hz.stall     = stall_w;
    hz.flush_e   = stall_w;
    hz.stall_cnt = cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rec_e <= '0;
      rec_m <= '0;
      rec_w <= '0;
      cnt_q <= '0;
    end else begin
      rec_w <= rec_m;
      rec_m <= rec_m_next;
      if (stall_w) rec_e <= '0;
      else         rec_e <= rec_d;
      if (stall_w && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
    end
  end

  // Record fields carried for completeness but not consumed by any select.
  always_comb unused_rec_bits = ^{rec_m.rs, rec_w.rs, rec_w.rt, rec_w.tnew};

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl; a narrow-counter twin covers saturation.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.SEL_W(3), .CNT_W(16)) hz ();
  hazard_ctrl_if #(.SEL_W(3), .CNT_W(6))  hz_s ();

  hazard_ctrl #(.SEL_W(3), .CNT_W(16)) u_dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  hazard_ctrl #(.SEL_W(3), .CNT_W(6)) u_small (
    .clk   (clk),
    .reset (reset),
    .hz    (hz_s)
  );

  typedef struct {
    logic [2:0]  drs, drt, ers, ert, mrt;
    logic        stall;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];

  function automatic exp_t mk(input int drs, input int drt, input int ers, input int ert,
                              input int mrt, input int st, input int cnt);
    exp_t x;
    x.drs = 3'(drs); x.drt = 3'(drt); x.ers = 3'(ers); x.ert = 3'(ert);
    x.mrt = 3'(mrt); x.stall = 1'(st); x.cnt = 16'(cnt);
    return x;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic set_d(input logic [4:0] rs, input logic [4:0] rt, input logic [1:0] trs,
                       input logic [1:0] trt, input logic [4:0] a3, input logic [1:0] kind);
    hz.rs_d = rs;   hz.rt_d = rt;   hz.tuse_rs_d = trs;   hz.tuse_rt_d = trt;
    hz.a3_d = a3;   hz.kind_d = kind;
    hz_s.rs_d = rs; hz_s.rt_d = rt; hz_s.tuse_rs_d = trs; hz_s.tuse_rt_d = trt;
    hz_s.a3_d = a3; hz_s.kind_d = kind;
  endtask

  task automatic compare_front();
    exp_t x;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
      return;
    end
    x = sb.pop_front();
    chk("fwd_rs_d",  32'(hz.fwd_rs_d),  32'(x.drs));
    chk("fwd_rt_d",  32'(hz.fwd_rt_d),  32'(x.drt));
    chk("fwd_rs_e",  32'(hz.fwd_rs_e),  32'(x.ers));
    chk("fwd_rt_e",  32'(hz.fwd_rt_e),  32'(x.ert));
    chk("fwd_rt_m",  32'(hz.fwd_rt_m),  32'(x.mrt));
    chk("stall",     32'(hz.stall),     32'(x.stall));
    chk("flush_e",   32'(hz.flush_e),   32'(x.stall));
    chk("stall_cnt", 32'(hz.stall_cnt), 32'(x.cnt));
    chk("cnt_small", 32'(hz_s.stall_cnt), (x.cnt > 16'd63) ? 32'd63 : 32'(x.cnt));
  endtask

  task automatic step(input logic [4:0] rs, input logic [4:0] rt, input logic [1:0] trs,
                      input logic [1:0] trt, input logic [4:0] a3, input logic [1:0] kind,
                      input exp_t e);
    set_d(rs, rt, trs, trt, a3, kind);
    sb.push_back(e);
    #1;
    compare_front();
    @(posedge clk);
    #1;
  endtask

  task automatic nop(input exp_t e);
    step(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, e);
  endtask

  initial begin
    int ns;
    set_d(5'd8, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    sb.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    compare_front();
    reset = 1'b0;

    // no prior writes
    step(8, 0, 0, 3, 0, 0, mk(0, 0, 0, 0, 0, 0, 0));
    // addu r8 then beq r8 (tuse 0): one stall, then ao forward
    step(0, 0, 3, 3, 8, 1, mk(0, 0, 0, 0, 0, 0, 0));
    step(8, 0, 0, 3, 0, 0, mk(0, 0, 0, 0, 0, 1, 0));
    step(8, 0, 0, 3, 0, 0, mk(2, 0, 0, 0, 0, 0, 1));
    // lw r9 then addu rs=9 (tuse 1): one stall, E gets wd once lw is in W
    step(0, 0, 3, 3, 9, 2, mk(0, 0, 4, 0, 0, 0, 1));
    step(9, 0, 1, 3, 10, 1, mk(0, 0, 0, 0, 0, 1, 1));
    step(9, 0, 1, 3, 10, 1, mk(0, 0, 0, 0, 0, 0, 2));
    nop(mk(0, 0, 4, 0, 0, 0, 2));
    // jal r31 then jr r31 (tuse 0): no stall, pc4e forward
    step(0, 0, 3, 3, 31, 3, mk(0, 0, 0, 0, 0, 0, 2));
    step(31, 0, 0, 3, 0, 0, mk(1, 0, 0, 0, 0, 0, 2));
    // two alu writers of r5; M must win over W in E-stage select
    step(0, 0, 3, 3, 5, 1, mk(0, 0, 3, 0, 0, 0, 2));
    step(0, 0, 3, 3, 5, 1, mk(0, 0, 0, 0, 0, 0, 2));
    step(5, 5, 1, 3, 0, 0, mk(0, 0, 0, 0, 0, 0, 2));
    nop(mk(0, 0, 2, 2, 0, 0, 2));
    nop(mk(0, 0, 0, 0, 4, 0, 2));
    // write to r0 followed by r0 readers
    step(0, 0, 3, 3, 0, 1, mk(0, 0, 0, 0, 0, 0, 2));
    step(0, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 2));
    step(0, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 2));
    // lw r12 then store of r12 (tuse_rt 2): no stall, M-stage wd forward
    step(0, 0, 3, 3, 12, 2, mk(0, 0, 0, 0, 0, 0, 2));
    step(0, 12, 3, 2, 0, 0, mk(0, 0, 0, 0, 0, 0, 2));
    nop(mk(0, 0, 0, 0, 0, 0, 2));
    nop(mk(0, 0, 0, 0, 4, 0, 2));
    // alu r7 then rt reader tuse 0: rt-path stall
    step(0, 0, 3, 3, 7, 1, mk(0, 0, 0, 0, 0, 0, 2));
    step(0, 7, 3, 0, 0, 0, mk(0, 0, 0, 0, 0, 1, 2));
    step(0, 7, 3, 0, 0, 0, mk(0, 2, 0, 0, 0, 0, 3));
    nop(mk(0, 0, 0, 4, 0, 0, 3));
    // reset during a lw-use stall
    step(0, 0, 3, 3, 9, 2, mk(0, 0, 0, 0, 0, 0, 3));
    set_d(5'd9, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0);
    sb.push_back(mk(0, 0, 0, 0, 0, 1, 3));
    #1;
    compare_front();
    reset = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    compare_front();
    reset = 1'b0;

    // self-dependent lw stream: stalls two of every three cycles
    ns = 0;
    for (int k = 0; k < 120; k++) begin
      step(9, 0, 0, 3, 9, 2,
           mk(((k % 3 == 0) && (k > 0)) ? 4 : 0, 0, 0, 0, 0, (k % 3 != 0) ? 1 : 0, ns));
      if (k % 3 != 0) ns++;
    end
    nop(mk(0, 0, 0, 0, 0, 0, 80));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Producer side of the operand-forwarding path: tracks in-flight register writes through the E, M and W stages.
- Generates the 3-bit forward selects consumed by the D-, E- and M-stage forwarding muxes.
- Generates the stall/flush pair for the pipeline registers.
- Sits beside the datapath in the cpu top level and is fed by D-stage decode.

Parameters:
- SEL_W, 3, width of every forward-select output.
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high; clears all internal stage state on the clk edge
- rs_d  input  5  rs field of the instruction in D
- rt_d  input  5  rt field of the instruction in D
- tuse_rs_d  input  2  cycles until D instruction needs rs (0=D, 1=E, 2=M, 3=never)
- tuse_rt_d  input  2  same for rt
- a3_d  input  5  destination register of the instruction in D (0 = no write)
- kind_d  input  2  result source: 0 none, 1 alu, 2 dm, 3 pc (link writes PC+8)
- fwd_rs_d  output  3  forward select for the D-stage rs mux
- fwd_rt_d  output  3  forward select for the D-stage rt mux
- fwd_rs_e  output  3  forward select for the E-stage rs mux
- fwd_rt_e  output  3  forward select for the E-stage rt mux
- fwd_rt_m  output  3  forward select for the M-stage store-data mux
- stall  output  1  freeze PC and the F/D register
- flush_e  output  1  load a bubble into the D/E register
- stall_cnt  output  CNT_W  saturating count of stalled cycles

Behaviour:
- Forward select encoding:
  - 0 rd: no forward
  - 1 pc4e: PC4E+4
  - 2 ao
  - 3 pc4m: PC4M+4
  - 4 wd
  - 5..7 never driven.
- Stage records E, M, W each hold {rs, rt, a3, kind, tnew}.
- tnew at entry to E is 0 for pc, 1 for alu, 2 for dm, 0 for none.
- Each edge, when not stalled:
  - W <= M.
  - M <= E with tnew = max(tnew-1, 0).
  - E <= D fields.
- Each edge, when stalled:
  - E <= bubble (all zero).
  - M and W still advance.
- Reset:
  - All records zero, stall_cnt = 0.
  - Outputs therefore read all selects 0, stall 0, flush_e 0 in the first cycle after reset.
- A record "matches" register r iff r != 0 and rec.a3 == r and rec.kind != none.
- D-stage select, priority E > M > W, first match wins:
  - E match: kind pc gives 1; otherwise 0 (not ready).
  - M match: kind alu gives 2, pc gives 3, dm gives 0.
  - W match: 4.
- E-stage select, for E.rs / E.rt, priority M > W:
  - M match: alu gives 2, pc gives 3, dm gives 0.
  - W match: 4.
- M-stage select for M.rt: W match gives 4, else 0.
- stall (combinational) is 1 iff, for rs_d or rt_d with tuse != 3:
  - an E match has E.tnew > tuse, or
  - an M match has M.tnew > tuse.
- flush_e = stall.
- stall_cnt increments on each edge where stall=1 and reset=0; it holds at all-ones.
- Register 0 never produces a forward or a stall.
- Reset asserted mid-stall: records clear on that edge and stall drops the next cycle regardless of the D inputs.

Test Plan:
- Reset held 2 cycles, then D = {rs_d=8, a3_d=0}, no prior writes -> all selects 0, stall=0, stall_cnt=0.
- Cycle 1 D: addu a3=8 kind=alu. Cycle 2 D: beq rs=8 tuse_rs=0 -> stall=1, flush_e=1 for one cycle. Next cycle fwd_rs_d=2 (ao), stall=0, stall_cnt=1.
- lw a3=9 kind=dm, followed by addu rs=9 tuse_rs=1:
  - stall=1 for exactly 1 cycle.
  - Then fwd_rs_e=2 is never issued; fwd_rs_e=4 (wd) once the lw reaches W.
- jal a3=31 kind=pc, followed by jr rs=31 tuse=0 -> no stall; fwd_rs_d=1 while jal in E.
- Both M and W match r=5 (alu in M) with E.rs=5 -> fwd_rs_e=2; priority check that W is ignored.
- Write to a3=0 kind=alu, followed by reader of r0 tuse=0 -> fwd=0, stall=0.
- Force stall for 2^16+3 cycles -> stall_cnt saturates at 16'hFFFF.
- Assert reset during a lw-use stall -> stall=0 on the following cycle.
